// File: rtl/deframer.sv
// Receive-side deframer: unpacks payload bytes LSB-first into elements, checks the two-byte tail,
// and hunts for the tail sequence after a mismatch. Define DEFRAMER_STATS_EN for frame/error counters.
module deframer #(
    parameter int unsigned unpacked_width_p   = 1,
    parameter int unsigned packed_num_p       = 8,
    parameter int unsigned packet_len_elems_p = 75684,
    parameter logic [7:0]  tail_byte_0_p      = 8'h0D,
    parameter logic [7:0]  tail_byte_1_p      = 8'h0A
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    input  logic [7:0]                  data_i,
    output logic                        ready_o,
    output logic                        valid_o,
    output logic [unpacked_width_p-1:0] unpacked_o,
    output logic                        last_o,
    input  logic                        ready_i,
    output logic                        frame_done_o,
    output logic                        frame_err_o
`ifdef DEFRAMER_STATS_EN
    ,
    output logic [15:0]                 frame_count_o,
    output logic [15:0]                 err_count_o
`endif
);

    localparam int unsigned CW = $clog2(packet_len_elems_p + 1);
    localparam int unsigned HW = $clog2(packed_num_p + 1);
    localparam logic [CW-1:0] LEN_C    = CW'(packet_len_elems_p);
    localparam logic [CW-1:0] LAST_IDX = CW'(packet_len_elems_p - 1);
    localparam logic [CW-1:0] PN_C     = CW'(packed_num_p);

    typedef enum logic [2:0] {
        S_PAYLOAD,
        S_TAIL0,
        S_TAIL1,
        S_HUNT,
        S_HUNT_T1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [HW-1:0] left_q, left_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] remaining;
    logic          done_q, done_d, err_q, err_d;
    logic          accept, retire;

    // hold_q shifts right as elements retire, so the current element is always at the bottom.
    assign valid_o      = (state_q == S_PAYLOAD) && (left_q != '0);
    assign unpacked_o   = hold_q[unpacked_width_p-1:0];
    assign last_o       = valid_o && (cnt_q == LAST_IDX);
    assign retire       = valid_o && ready_i;
    assign ready_o      = !reset_i && ((state_q != S_PAYLOAD) || (left_q == '0) ||
                                       (retire && (left_q == HW'(1)) && !last_o));
    assign accept       = valid_i && ready_o;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        remaining = '0;
        case (state_q)
            S_PAYLOAD: begin
                if (retire) begin
                    hold_d = hold_q >> unpacked_width_p;
                    left_d = left_q - HW'(1);
                    if (last_o) begin
                        cnt_d   = '0;
                        state_d = S_TAIL0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                // A short final byte only exposes the elements still owed to the frame.
                if (accept) begin
                    hold_d    = data_i;
                    remaining = LEN_C - cnt_d;
                    left_d    = (remaining >= PN_C) ? HW'(packed_num_p) : HW'(remaining);
                end
            end
            S_TAIL0: begin
                if (accept) begin
                    if (data_i == tail_byte_0_p) begin
                        state_d = S_TAIL1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end
                end
            end
            S_TAIL1: begin
                if (accept) begin
                    if (data_i == tail_byte_1_p) begin
                        done_d  = 1'b1;
                        state_d = S_PAYLOAD;
                    end else if (data_i == tail_byte_0_p) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end
                end
            end
            S_HUNT: begin
                if (accept && (data_i == tail_byte_0_p)) state_d = S_HUNT_T1;
            end
            S_HUNT_T1: begin
                if (accept) begin
                    if (data_i == tail_byte_1_p)      state_d = S_PAYLOAD;
                    else if (data_i != tail_byte_0_p) state_d = S_HUNT;
                end
            end
            default: state_d = S_PAYLOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_PAYLOAD;
            hold_q  <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef DEFRAMER_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_count_o <= '0;
            err_count_o   <= '0;
        end else begin
            if (done_q && (frame_count_o != 16'hFFFF)) frame_count_o <= frame_count_o + 16'd1;
            if (err_q && (err_count_o != 16'hFFFF))    err_count_o   <= err_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_deframer.sv
// Bench for deframer with a 12-element frame; a byte-level model of the framing rules
// queues the expected {last, element} pairs and tail pulse counts.
module tb_deframer;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       valid_o;
    logic [0:0] unpacked_o;
    logic       last_o;
    logic       ready_i;
    logic       frame_done_o;
    logic       frame_err_o;
`ifdef DEFRAMER_STATS_EN
    logic [15:0] frame_count_o;
    logic [15:0] err_count_o;
`endif

    deframer #(
        .unpacked_width_p  (1),
        .packed_num_p      (8),
        .packet_len_elems_p(12)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .unpacked_o   (unpacked_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .frame_done_o (frame_done_o),
        .frame_err_o  (frame_err_o)
`ifdef DEFRAMER_STATS_EN
        ,
        .frame_count_o(frame_count_o),
        .err_count_o  (err_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];
    int exp_done = 0, exp_err = 0, obs_done = 0, obs_err = 0;
    int m_mode = 0, m_pos = 0;
    int ret_cnt = 0;
    int rdy_mode = 0;
    logic       prev_stall = 1'b0;
    logic [0:0] prev_elem = '0;
    logic [1:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Framing rules at byte granularity: 12 elements (two bytes, last one short), then 0D 0A.
    task automatic model_byte(input logic [7:0] b);
        int n;
        case (m_mode)
            0: begin
                n = (12 - m_pos >= 8) ? 8 : 12 - m_pos;
                for (int k = 0; k < n; k++) exp_q.push_back({(m_pos + k == 11), b[k]});
                m_pos += n;
                if (m_pos == 12) begin m_pos = 0; m_mode = 1; end
            end
            1: if (b == 8'h0D) m_mode = 2; else begin exp_err++; m_mode = 3; end
            2: if (b == 8'h0A) begin exp_done++; m_mode = 0; end
               else if (b == 8'h0D) exp_err++;
               else begin exp_err++; m_mode = 3; end
            3: if (b == 8'h0D) m_mode = 4;
            default: if (b == 8'h0A) m_mode = 0; else if (b != 8'h0D) m_mode = 3;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        model_byte(b);
        data_i  = b;
        valid_i = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!acc) chk("accept_timeout", acc, 1);
        valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_done"}, obs_done, exp_done);
        chk({tag, "_err"}, obs_err, exp_err);
    endtask

    initial begin : rdy_drv
        int ph;
        ph = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                1: begin ready_i = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
                2: ready_i = ($urandom_range(0, 3) != 0);
                default: ready_i = 1'b1;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_data", unpacked_o, prev_elem);
            end
            if (valid_o && !ready_i) chk("ready_o_while_held", ready_o, 0);
            if (valid_o && ready_i) begin
                ret_cnt++;
                if (exp_q.size() == 0) begin
                    chk("elem_unexpected", valid_o, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("elem", unpacked_o, mon_e[0]);
                    chk("last", last_o, mon_e[1]);
                end
            end
            if (frame_done_o) obs_done++;
            if (frame_err_o) obs_err++;
            prev_stall = valid_o && !ready_i;
            prev_elem  = unpacked_o;
        end
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_err", frame_err_o, 0);
        reset_i = 1'b0;
        #1;
        chk("idle_ready", ready_o, 1);

        rdy_mode = 0;
        send_frame(8'hA5, 8'h03);
        drain("nominal");

        send_frame(8'hA5, 8'hF3);
        drain("padding");

        rdy_mode = 1;
        send_frame(8'hA5, 8'h03);
        drain("backpressure");

        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h0D); send_byte(8'h55);
        send_byte(8'h11); send_byte(8'h0D); send_byte(8'h0A);
        send_frame(8'h3C, 8'h0D);
        drain("bad_tail");

        send_byte(8'h0A); send_byte(8'h0D); send_byte(8'h0D); send_byte(8'h0D); send_byte(8'h0A);
        send_frame(8'h0D, 8'h0A);
        drain("tail1_repeat");

        ret_cnt = 0;
        send_byte(8'hC6);
        for (int i = 0; i < 50 && ret_cnt < 5; i++) begin @(posedge clk_i); #1; end
        chk("pre_reset_valid", valid_o, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_last", last_o, 0);
        chk("mid_rst_ready", ready_o, 0);
        exp_q.delete();
        m_mode = 0;
        m_pos  = 0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        send_frame(8'h96, 8'h0E);
        drain("after_reset");

        rdy_mode = 2;
        for (int f = 0; f < 8; f++) begin
            send_frame($urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                send_byte($urandom_range(0, 255));
                send_byte($urandom_range(0, 255));
                send_byte($urandom_range(0, 255));
                send_byte(8'h0D);
                send_byte(8'h0A);
            end
        end
        drain("random");

`ifdef DEFRAMER_STATS_EN
        chk("frame_count", frame_count_o, exp_done);
        chk("err_count", err_count_o, exp_err);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
